// File: rtl/synapse_weight_store.sv
// Synapse weight store: AXI4-Lite programmable weight array with a dedicated
// single-cycle fetch port for the neuron core that is never stalled by AXI.
module synapse_weight_store #(
  parameter int NUM_SYNAPSES = 205,
  parameter int WEIGHT_WIDTH = 16,
  localparam int IDX_W = (NUM_SYNAPSES > 1) ? $clog2(NUM_SYNAPSES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [31:0]             s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic                    core_rd_en,
  input  logic [IDX_W-1:0]        core_rd_addr,
  output logic                    core_rd_valid,
  output logic [WEIGHT_WIDTH-1:0] core_rd_data
);

  // Handshakes: a beat transfers on the rising edge where valid and ready are
  // both high; valid never waits on ready, and every ready here depends only on
  // registered state (plus rst, which forces all readies low while asserted).

  typedef enum logic [2:0] {
    W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP
  } wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [WEIGHT_WIDTH-1:0] mem [NUM_SYNAPSES];

  wr_state_e               wr_state_q, wr_state_d;
  logic                    aw_held_q, aw_held_d;
  logic [29:0]             aw_idx_q, aw_idx_d;
  logic                    w_held_q, w_held_d;
  logic [WEIGHT_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;

  rd_state_e               rd_state_q, rd_state_d;
  logic                    rvalid_q, rvalid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    core_valid_q, core_valid_d;
  logic [WEIGHT_WIDTH-1:0] core_data_q, core_data_d;

  logic                    aw_hs, w_hs, ar_hs;
  logic                    aw_in_range, ar_in_range, core_in_range;
  logic [IDX_W-1:0]        ar_idx;
  logic [31:0]             strb_mask;
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_widx;
  logic [WEIGHT_WIDTH-1:0] mem_wval;
  logic                    unused_bits;

  assign s_axi_awready = ~rst & ~aw_held_q & ~bvalid_q;
  assign s_axi_wready  = ~rst & ~w_held_q & ~bvalid_q;
  assign s_axi_arready = ~rst & (rd_state_q == R_IDLE);
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign core_rd_valid = core_valid_q;
  assign core_rd_data  = core_data_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  assign aw_in_range   = {2'b00, aw_idx_q} < 32'(NUM_SYNAPSES);
  assign ar_in_range   = {2'b00, s_axi_araddr[31:2]} < 32'(NUM_SYNAPSES);
  assign core_in_range = 32'(core_rd_addr) < 32'(NUM_SYNAPSES);
  assign ar_idx        = s_axi_araddr[IDX_W+1:2];
  assign strb_mask     = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

  // Low address bits, data above the weight width and strobes for lanes the
  // weight does not reach are intentionally ignored.
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata, strb_mask};

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    mem_widx   = aw_idx_q[IDX_W-1:0];
    mem_wval   = (mem[mem_widx] & ~strb_mask[WEIGHT_WIDTH-1:0])
               | (wdata_q & strb_mask[WEIGHT_WIDTH-1:0]);
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi_awaddr[31:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata[WEIGHT_WIDTH-1:0];
      wstrb_d  = s_axi_wstrb;
    end
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = W_COMMIT;
        else if (aw_hs)    wr_state_d = W_HAVE_ADDR;
        else if (w_hs)     wr_state_d = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs) wr_state_d = W_COMMIT;
      W_HAVE_DATA: if (aw_hs) wr_state_d = W_COMMIT;
      W_COMMIT: begin
        mem_we     = aw_in_range;
        bvalid_d   = 1'b1;
        bresp_d    = aw_in_range ? RESP_OKAY : RESP_SLVERR;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rvalid_d   = 1'b1;
          rdata_d    = ar_in_range ? 32'(mem[ar_idx]) : 32'd0;
          rresp_d    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Core fetch has its own read port so AXI activity can never delay it.
  always_comb begin
    core_valid_d = core_rd_en;
    core_data_d  = core_data_q;
    if (core_rd_en) core_data_d = core_in_range ? mem[core_rd_addr] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q   <= W_IDLE;
      aw_held_q    <= 1'b0;
      aw_idx_q     <= '0;
      w_held_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rd_state_q   <= R_IDLE;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      core_valid_q <= 1'b0;
      core_data_q  <= '0;
    end else begin
      wr_state_q   <= wr_state_d;
      aw_held_q    <= aw_held_d;
      aw_idx_q     <= aw_idx_d;
      w_held_q     <= w_held_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rd_state_q   <= rd_state_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      core_valid_q <= core_valid_d;
      core_data_q  <= core_data_d;
    end
  end

  // Weight contents survive reset; the write FSM sits in W_IDLE during reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wval;
  end

endmodule

// File: doc/synapse_weight_store.md
SYNAPSE_WEIGHT_STORE -- requirements
Module: synapse_weight_store

Interface
REQ-001 Parameter NUM_SYNAPSES, default 205: number of weight words; legal range 1..65536.
REQ-002 Parameter WEIGHT_WIDTH, default 16: bits per weight; legal range 1..32.
REQ-003 Localparam IDX_W = max(1, clog2(NUM_SYNAPSES)): width of the core-port index.
REQ-004 clk  in  1: single clock; all logic rising-edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 s_axi_awaddr/awvalid/awready  in/in/out  32/1/1: AXI4-Lite write address channel.
REQ-007 s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1: AXI4-Lite write data channel.
REQ-008 s_axi_bresp/bvalid/bready  out/out/in  2/1/1: AXI4-Lite write response channel.
REQ-009 s_axi_araddr/arvalid/arready  in/in/out  32/1/1: AXI4-Lite read address channel.
REQ-010 s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1: AXI4-Lite read data channel.
REQ-011 core_rd_en/core_rd_addr  in/in  1/IDX_W: neuron-core weight fetch request.
REQ-012 core_rd_valid/core_rd_data  out/out  1/WEIGHT_WIDTH: neuron-core fetch result.

Function
REQ-013 Storage: NUM_SYNAPSES x WEIGHT_WIDTH array; word index = address[31:2]; address[1:0] ignored.
REQ-014 AW and W channels independent: each accepted in any order or same cycle, each held in its own holding register.
REQ-015 awready = 1 iff no address held and bvalid = 0; wready = 1 iff no data held and bvalid = 0; both combinational from registered state only.
REQ-016 Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP; IDLE->HAVE_ADDR/HAVE_DATA on single acceptance; ->COMMIT when both held; COMMIT->RESP after one cycle; RESP->IDLE on bvalid && bready.
REQ-017 COMMIT: index < NUM_SYNAPSES -> array written, bresp = OKAY(00); otherwise no write, bresp = SLVERR(10).
REQ-018 Byte strobes: weight bit i updated only if wstrb[i/8] = 1; bits beyond WEIGHT_WIDTH discarded; wstrb = 0 still returns OKAY with no change.
REQ-019 bvalid asserted the cycle after COMMIT; bvalid, bresp stable until bready.
REQ-020 Read FSM states: R_IDLE, R_DATA; arready = 1 iff state R_IDLE.
REQ-021 AR handshake -> next cycle rvalid = 1, rdata = zero-extended weight, rresp = OKAY; out of range -> rdata = 0, rresp = SLVERR.
REQ-022 rvalid, rdata, rresp held until rready; R_DATA->R_IDLE on rvalid && rready; next AR accepted no earlier than the following cycle.
REQ-023 Read and write paths fully concurrent; AXI read of an index committed in the same cycle returns the old value.
REQ-024 Core port: core_rd_en sampled each cycle; core_rd_valid = 1 and core_rd_data = weight exactly one cycle later; never stalled by AXI traffic.
REQ-025 Core index >= NUM_SYNAPSES -> core_rd_data = 0, core_rd_valid still 1.
REQ-026 Core read same index as same-cycle commit returns old value; new value visible from next cycle.
REQ-027 Back-to-back core reads every cycle sustain one result per cycle.

Reset
REQ-028 rst asserted: immediately awready = wready = arready = 0 for reset duration, bvalid = rvalid = core_rd_valid = 0, bresp = rresp = 00, rdata = 0, core_rd_data = 0, FSMs to W_IDLE/R_IDLE, holding registers cleared.
REQ-029 Weight array not reset; in-flight transactions abandoned, no partial write.
REQ-030 First cycle after rst deassertion: awready = wready = arready = 1.

Verification
REQ-031 W (wdata 0x0000ABCD, wstrb 1111) two cycles before AW (addr 0x10) -> bvalid, bresp 00; AXI read 0x10 -> rdata 0x0000ABCD, rresp 00.
REQ-032 Write addr 4*205 = 0x334 -> bresp 10, array unchanged; read 0x334 -> rdata 0, rresp 10.
REQ-033 Index 3 holds 0x1234; write 0x0000FF77 with wstrb 0001 -> index 3 = 0x1277.
REQ-034 bready held 0 for 5 cycles -> bvalid, bresp stable, awready = wready = 0 throughout; rready low -> rdata stable.
REQ-035 core_rd_en every cycle, indices 0..7, while AXI writes index 2 -> one core_rd_valid per cycle, latency 1, old value at commit cycle, new after.
REQ-036 rst pulsed mid-write (AW accepted, W pending) -> outputs at reset values asynchronously; target index unchanged.
